vme_reg_readback: RTL



---
 rtl/vme_reg_readback.sv | 116 +++++++++++
 1 files changed

// File: rtl/vme_reg_readback.sv
// Status readback responder: two-stage sync pipe, snapshot shadow bank and level req/ack read port.
// Define VME_RB_LIVE_EN to expose live (unsnapshotted) words at addresses NWORDS..2*NWORDS-1.
module vme_reg_readback #(
  parameter int NWORDS = 16,
  parameter int AW     = 5
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [NWORDS*32-1:0]   stat_in,
  input  logic                   snap_req,
  input  logic                   rd_req,
  input  logic [AW-1:0]          rd_addr,
  output logic [31:0]            rd_data,
  output logic                   rd_ack,
  output logic                   rd_err,
  output logic                   snap_busy,
  output logic [15:0]            snap_count
);

  // state     | meaning
  // ST_IDLE   | waiting for rd_req; snapshots may execute
  // ST_LOOKUP | decoding latched address into rd_data/rd_err
  // ST_ACK    | rd_ack high until rd_req drops
  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_LOOKUP = 2'd1;
  localparam logic [1:0] ST_ACK    = 2'd2;

  localparam int IW = (NWORDS > 1) ? $clog2(NWORDS) : 1;

  logic [1:0]            state;
  logic [NWORDS*32-1:0]  s1, s2;
  logic [31:0]           shadow [NWORDS];
  logic                  pending;
  logic [AW-1:0]         addr_q;
  logic [AW:0]           addr_ext;
  logic                  idle_edge;
  logic                  snap_exec;
  logic [31:0]           dec_data;
  logic                  dec_err;

  assign addr_ext  = {1'b0, addr_q};
  assign snap_busy = pending;

  // The ACK->IDLE edge counts as idle so a deferred snapshot lands on the edge the read closes.
  assign idle_edge = (state == ST_IDLE) || ((state == ST_ACK) && !rd_req);
  assign snap_exec = idle_edge && (snap_req || pending);

  always_comb begin
    dec_data = 32'hDEADBEEF;
    dec_err  = 1'b1;
    if (addr_ext < (AW+1)'(NWORDS)) begin
      dec_data = shadow[addr_q[IW-1:0]];
      dec_err  = 1'b0;
    end
`ifdef VME_RB_LIVE_EN
    else begin
      for (int k = 0; k < NWORDS; k++) begin
        if (addr_ext == (AW+1)'(NWORDS + k)) begin
          dec_data = s2[32*k +: 32];
          dec_err  = 1'b0;
        end
      end
    end
`endif
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= ST_IDLE;
      s1         <= '0;
      s2         <= '0;
      pending    <= 1'b0;
      snap_count <= '0;
      addr_q     <= '0;
      rd_data    <= '0;
      rd_ack     <= 1'b0;
      rd_err     <= 1'b0;
      for (int k = 0; k < NWORDS; k++) shadow[k] <= '0;
    end else begin
      s1 <= stat_in;
      s2 <= s1;

      if (snap_exec) begin
        for (int k = 0; k < NWORDS; k++) shadow[k] <= s2[32*k +: 32];
        pending    <= 1'b0;
        snap_count <= snap_count + 16'd1;
      end else if (snap_req) begin
        pending <= 1'b1;
      end

      case (state)
        ST_IDLE: begin
          if (rd_req) begin
            addr_q <= rd_addr;
            state  <= ST_LOOKUP;
          end
        end
        ST_LOOKUP: begin
          rd_data <= dec_data;
          rd_err  <= dec_err;
          rd_ack  <= 1'b1;
          state   <= ST_ACK;
        end
        ST_ACK: begin
          if (!rd_req) begin
            rd_ack <= 1'b0;
            rd_err <= 1'b0;
            state  <= ST_IDLE;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule
